// File: rtl/ascon_perm_ctrl_pkg.sv
// Shared types, round constants and rotation amounts for the Ascon permutation controller.
// Pure declarations, no logic; backpressure n/a.
package ascon_perm_ctrl_pkg;

   typedef logic [4:0][63:0] ascon_state_t;

   typedef enum logic [1:0] {
      MODE_INIT = 2'd0,
      MODE_PA   = 2'd1,
      MODE_PB   = 2'd2
   } ascon_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUND  = 2'd1,
      ST_KEYXOR = 2'd2,
      ST_WB     = 2'd3
   } ctrl_state_e;

   // Linear-layer rotate-right amounts per lane x0..x4.
   localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

   localparam int unsigned MAX_ROUNDS = 12;

   function automatic logic [7:0] rc(input logic [3:0] idx);
      return {4'hF - idx, idx};
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
      return (x >> n) | (x << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_perm_ctrl_round.sv
// One combinational Ascon round: constant add, bit-sliced 5-bit S-box, linear diffusion.
// Zero latency; no flow control.
module ascon_perm_ctrl_round
   import ascon_perm_ctrl_pkg::*;
(
   input  ascon_state_t state_i,
   input  logic [7:0]   rc_i,
   output ascon_state_t state_o
);

   logic [63:0] x0, x1, x2, x3, x4;
   logic [63:0] y0, y1, y2, y3, y4;
   ascon_state_t sb;

   // Constant add folded into the S-box input mixing on x2.
   assign x0 = state_i[0] ^ state_i[4];
   assign x1 = state_i[1];
   assign x2 = state_i[2] ^ {56'd0, rc_i} ^ state_i[1];
   assign x3 = state_i[3];
   assign x4 = state_i[4] ^ state_i[3];

   assign y0 = x0 ^ (~x1 & x2);
   assign y1 = x1 ^ (~x2 & x3);
   assign y2 = x2 ^ (~x3 & x4);
   assign y3 = x3 ^ (~x4 & x0);
   assign y4 = x4 ^ (~x0 & x1);

   assign sb[0] = y0 ^ y4;
   assign sb[1] = y1 ^ y0;
   assign sb[2] = ~y2;
   assign sb[3] = y3 ^ y2;
   assign sb[4] = y4;

   for (genvar i = 0; i < 5; i++) begin : g_lin
      assign state_o[i] = sb[i] ^ ror64(sb[i], ROT_A[i]) ^ ror64(sb[i], ROT_B[i]);
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation sequencer: one round per cycle, WB after R (+1 for INIT key XOR) rounds.
// start_i ignored while busy (no queuing); abort_i returns to IDLE without write-back.
module ascon_perm_ctrl
   import ascon_perm_ctrl_pkg::*;
#(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [1:0]   mode_i,
   input  logic         abort_i,
   input  logic         intr_en_i,
   input  ascon_state_t state_i,
   input  logic [127:0] key_i,
   output ascon_state_t state_o,
   output logic         update_state_o,
   output logic         busy_o,
   output logic         finished_o,
   output logic         intr_o
);

   ctrl_state_e  st_q;
   ascon_mode_e  mode_q;
   logic [3:0]   cnt_q;
   logic [3:0]   rounds_q;
   ascon_state_t state_q;
   ascon_state_t round_out;
   logic [127:0] key_q;
   logic         finished_q;
   logic         intr_q;
   logic [3:0]   rc_idx;
   logic [7:0]   rc_val;
   logic         last_round;

   // pb is the tail of the pa schedule, so the index is offset by 12-R.
   assign rc_idx     = 4'(MAX_ROUNDS) - rounds_q + cnt_q;
   assign rc_val     = rc(rc_idx);
   assign last_round = (cnt_q == rounds_q - 4'd1);

   ascon_perm_ctrl_round u_round (
      .state_i (state_q),
      .rc_i    (rc_val),
      .state_o (round_out)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q       <= ST_IDLE;
         mode_q     <= MODE_INIT;
         cnt_q      <= '0;
         rounds_q   <= '0;
         state_q    <= '0;
         key_q      <= '0;
         finished_q <= 1'b0;
         intr_q     <= 1'b0;
      end else begin
         intr_q <= 1'b0;
         case (st_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q    <= state_i;
                  key_q      <= key_i;
                  cnt_q      <= '0;
                  finished_q <= 1'b0;
                  st_q       <= ST_ROUND;
                  if (mode_i == 2'd2) begin
                     mode_q   <= MODE_PB;
                     rounds_q <= 4'(ROUNDS_B);
                  end else begin
                     mode_q   <= (mode_i == 2'd0) ? MODE_INIT : MODE_PA;
                     rounds_q <= 4'(ROUNDS_A);
                  end
               end
            end
            ST_ROUND: begin
               if (abort_i) begin
                  st_q <= ST_IDLE;
               end else begin
                  state_q <= round_out;
                  cnt_q   <= cnt_q + 4'd1;
                  if (last_round) begin
                     st_q <= (mode_q == MODE_INIT) ? ST_KEYXOR : ST_WB;
                  end
               end
            end
            ST_KEYXOR: begin
               if (abort_i) begin
                  st_q <= ST_IDLE;
               end else begin
                  state_q[3] <= state_q[3] ^ key_q[127:64];
                  state_q[4] <= state_q[4] ^ key_q[63:0];
                  st_q       <= ST_WB;
               end
            end
            ST_WB: begin
               st_q <= ST_IDLE;
               if (!abort_i) begin
                  finished_q <= 1'b1;
                  intr_q     <= intr_en_i;
               end
            end
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   assign state_o        = state_q;
   assign update_state_o = (st_q == ST_WB);
   assign busy_o         = (st_q != ST_IDLE);
   assign finished_o     = finished_q;
   assign intr_o         = intr_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: table-driven and random runs against a
// table-based (S-box lookup) reference permutation, plus hand-written corner sequences.
module tb_ascon_perm_ctrl;

   typedef logic [4:0][63:0] st_t;
   typedef struct {
      logic [1:0] mode;
      logic       ien;
      int         wb_cycle;
      logic       intr_exp;
   } vec_t;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam logic [7:0] RC_TAB [12] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
   localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
   localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

   logic         clk = 1'b0;
   logic         rst_i, start_i, abort_i, intr_en_i;
   logic [1:0]   mode_i;
   st_t          state_i, state_o;
   logic [127:0] key_i;
   logic         update_state_o, busy_o, finished_o, intr_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ascon_perm_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .mode_i         (mode_i),
      .abort_i        (abort_i),
      .intr_en_i      (intr_en_i),
      .state_i        (state_i),
      .key_i          (key_i),
      .state_o        (state_o),
      .update_state_o (update_state_o),
      .busy_o         (busy_o),
      .finished_o     (finished_o),
      .intr_o         (intr_o)
   );

   function automatic logic [63:0] rr(input logic [63:0] x, input int n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   function automatic st_t model_round(input st_t s, input int idx);
      st_t t;
      logic [4:0] v, o;
      s[2][7:0] = s[2][7:0] ^ RC_TAB[idx];
      for (int b = 0; b < 64; b++) begin
         v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
         o = SBOX[v];
         for (int i = 0; i < 5; i++) t[i][b] = o[4-i];
      end
      for (int i = 0; i < 5; i++) s[i] = t[i] ^ rr(t[i], ROT1[i]) ^ rr(t[i], ROT2[i]);
      return s;
   endfunction

   // First k rounds of an R-round permutation (pb uses the last R constants).
   function automatic st_t model_perm(input st_t s, input int r, input int k);
      for (int j = 0; j < k; j++) s = model_round(s, 12 - r + j);
      return s;
   endfunction

   function automatic st_t rand_state();
      st_t s;
      for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] mode, input st_t s, input logic [127:0] k,
                         input logic ien, input int wb, input logic iexp, input string tag);
      int  r;
      st_t fin;
      r   = (mode == 2'd2) ? 6 : 12;
      fin = model_perm(s, r, r);
      if (mode == 2'd0) begin
         fin[3] = fin[3] ^ k[127:64];
         fin[4] = fin[4] ^ k[63:0];
      end
      start_i = 1'b1; mode_i = mode; state_i = s; key_i = k; intr_en_i = ien;
      step();
      start_i = 1'b0; state_i = ~s; key_i = ~k; mode_i = ~mode;
      for (int c = 1; c <= wb + 1; c++) begin
         chk($sformatf("%s_busy_c%0d", tag, c), busy_o, (c <= wb));
         chk($sformatf("%s_upd_c%0d", tag, c), update_state_o, (c == wb));
         chk($sformatf("%s_fin_c%0d", tag, c), finished_o, (c == wb + 1));
         chk($sformatf("%s_intr_c%0d", tag, c), intr_o, logic'(c == wb + 1) & iexp);
         if (c <= r + 1)
            chk($sformatf("%s_state_c%0d", tag, c), state_o, model_perm(s, r, c - 1));
         if (c >= wb)
            chk($sformatf("%s_result_c%0d", tag, c), state_o, fin);
         if (c <= wb) step();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs [6];
      st_t          s, s2, held;
      logic [127:0] k;
      logic [1:0]   m;
      logic         e;

      vecs[0] = '{mode: 2'd0, ien: 1'b1, wb_cycle: 14, intr_exp: 1'b1};
      vecs[1] = '{mode: 2'd1, ien: 1'b1, wb_cycle: 13, intr_exp: 1'b1};
      vecs[2] = '{mode: 2'd1, ien: 1'b0, wb_cycle: 13, intr_exp: 1'b0};
      vecs[3] = '{mode: 2'd2, ien: 1'b1, wb_cycle: 7,  intr_exp: 1'b1};
      vecs[4] = '{mode: 2'd2, ien: 1'b0, wb_cycle: 7,  intr_exp: 1'b0};
      vecs[5] = '{mode: 2'd3, ien: 1'b1, wb_cycle: 13, intr_exp: 1'b1};

      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; intr_en_i = 1'b0;
      mode_i = 2'd0; state_i = '0; key_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", state_o, '0);
      chk("rst_upd", update_state_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_fin", finished_o, 1'b0);
      chk("rst_intr", intr_o, 1'b0);
      rst_i = 1'b0;
      step();
      chk("idle_busy", busy_o, 1'b0);

      run_op(2'd2, '0, '0, 1'b0, 7, 1'b0, "pb_zero");

      s[0] = 64'h80400C0600000000;
      s[1] = 64'h0001020304050607;
      s[2] = 64'h08090A0B0C0D0E0F;
      s[3] = s[1];
      s[4] = s[2];
      run_op(2'd0, s, {s[1], s[2]}, 1'b1, 14, 1'b1, "init_kat");

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].mode, rand_state(), {$urandom, $urandom, $urandom, $urandom},
                vecs[i].ien, vecs[i].wb_cycle, vecs[i].intr_exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         m = 2'($urandom_range(0, 3));
         e = 1'($urandom_range(0, 1));
         run_op(m, rand_state(), {$urandom, $urandom, $urandom, $urandom}, e,
                (m == 2'd2) ? 7 : ((m == 2'd0) ? 14 : 13), e, $sformatf("rnd%0d", i));
      end

      // start held high: starts in cycles 1-7 ignored, second accepted in cycle 8
      step();
      s = rand_state(); s2 = rand_state(); k = {$urandom, $urandom, $urandom, $urandom};
      start_i = 1'b1; mode_i = 2'd2; state_i = s; key_i = k; intr_en_i = 1'b1;
      step();
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("b2b_busy_c%0d", c), busy_o, 1'b1);
         chk($sformatf("b2b_state_c%0d", c), state_o, model_perm(s, 6, c - 1));
         chk($sformatf("b2b_upd_c%0d", c), update_state_o, (c == 7));
         mode_i  = (c == 7) ? 2'd2 : 2'd0;
         state_i = (c == 7) ? s2 : rand_state();
         step();
      end
      chk("b2b_c8_busy", busy_o, 1'b0);
      chk("b2b_c8_fin", finished_o, 1'b1);
      chk("b2b_c8_intr", intr_o, 1'b1);
      step();
      chk("b2b_c9_busy", busy_o, 1'b1);
      chk("b2b_c9_fin", finished_o, 1'b0);
      chk("b2b_c9_state", state_o, s2);
      for (int c = 10; c <= 15; c++) begin
         if (c == 15) start_i = 1'b0;
         step();
      end
      chk("b2b_c15_upd", update_state_o, 1'b1);
      chk("b2b_c15_state", state_o, model_perm(s2, 6, 6));
      step();
      chk("b2b_c16_fin", finished_o, 1'b1);
      chk("b2b_c16_intr", intr_o, 1'b1);
      chk("b2b_c16_busy", busy_o, 1'b0);

      // abort in cycle 5 of PA
      s = rand_state();
      start_i = 1'b1; mode_i = 2'd1; state_i = s; intr_en_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk($sformatf("abort_busy_c%0d", c), busy_o, 1'b1);
         if (c == 5) abort_i = 1'b1;
         step();
      end
      abort_i = 1'b0;
      held = model_perm(s, 12, 4);
      for (int c = 6; c <= 16; c++) begin
         chk($sformatf("abort_busy_c%0d", c), busy_o, 1'b0);
         chk($sformatf("abort_upd_c%0d", c), update_state_o, 1'b0);
         chk($sformatf("abort_intr_c%0d", c), intr_o, 1'b0);
         chk($sformatf("abort_fin_c%0d", c), finished_o, 1'b0);
         chk($sformatf("abort_state_c%0d", c), state_o, held);
         step();
      end

      // abort in IDLE together with start: start wins
      s = rand_state();
      start_i = 1'b1; abort_i = 1'b1; mode_i = 2'd2; state_i = s;
      step();
      start_i = 1'b0; abort_i = 1'b0;
      chk("idleabort_busy", busy_o, 1'b1);
      chk("idleabort_state", state_o, s);
      for (int c = 2; c <= 7; c++) step();
      chk("idleabort_upd", update_state_o, 1'b1);
      chk("idleabort_result", state_o, model_perm(s, 6, 6));
      // abort during the WB cycle suppresses finished and interrupt
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("wbabort_fin", finished_o, 1'b0);
      chk("wbabort_intr", intr_o, 1'b0);
      chk("wbabort_busy", busy_o, 1'b0);

      // asynchronous reset mid-run in ROUND cycle 4
      s = rand_state(); k = {$urandom, $urandom, $urandom, $urandom};
      start_i = 1'b1; mode_i = 2'd0; state_i = s; key_i = k; intr_en_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 1; c < 4; c++) step();
      #3;
      rst_i = 1'b1;
      #1;
      chk("arst_state", state_o, '0);
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_upd", update_state_o, 1'b0);
      chk("arst_fin", finished_o, 1'b0);
      chk("arst_intr", intr_o, 1'b0);
      step();
      rst_i = 1'b0;
      step();
      chk("arst_idle_intr", intr_o, 1'b0);
      run_op(2'd0, rand_state(), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 14, 1'b1,
             "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
